// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle main control FSM for the MIPS CPU. Walks one instruction
//   through IF/ID/EX/MEM/WB, drives the shared datapath controls, stalls on the
//   unified-memory ready handshake and counts retired instructions.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   Op, Funct           IR[31:26] / IR[5:0]
//   Zero                ALU zero flag (EX)
//   MemReady            memory accepts the pending access at this edge
//   PCWrite, IRWrite    PC / IR load enables
//   IorD                memory address select (0=PC, 1=ALUOut)
//   MemRead, MemWrite   memory requests
//   RegWrite            regfile write enable
//   RegDst, MemtoReg    regfile destination / write-data selects
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ALUOp               operation class passed to ALUControl
//   PCSource            next-PC select
//   State               current state (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   InstRet             retired-instruction counter (wraps)
//   Illegal             one-cycle pulse for an unsupported Op/Funct in ID
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstRet,
    output logic             Illegal
);

    // ALUOp codes shared with ALUControl
    localparam logic [3:0] ALUOP_LS    = 4'd0;
    localparam logic [3:0] ALUOP_RTYPE = 4'd1;
    localparam logic [3:0] ALUOP_BEQ   = 4'd2;
    localparam logic [3:0] ALUOP_BNE   = 4'd3;
    localparam logic [3:0] ALUOP_ADDI  = 4'd4;
    localparam logic [3:0] ALUOP_ADDIU = 4'd5;
    localparam logic [3:0] ALUOP_ANDI  = 4'd6;
    localparam logic [3:0] ALUOP_ORI   = 4'd7;
    localparam logic [3:0] ALUOP_XORI  = 4'd8;
    localparam logic [3:0] ALUOP_SLTI  = 4'd9;
    localparam logic [3:0] ALUOP_SLTIU = 4'd10;
    localparam logic [3:0] ALUOP_LUI   = 4'd11;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Supported R-type function codes (shifts, arithmetic, logic, set, jr/jalr)
    function automatic logic f_funct_ok(input logic [5:0] fn);
        case (fn)
            6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
            6'b001000, 6'b001001,
            6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b101011: f_funct_ok = 1'b1;
            default:                                     f_funct_ok = 1'b0;
        endcase
    endfunction

    // I-type ALU opcodes map to their own ALUOp; 4'hF marks "not an I-type ALU op"
    function automatic logic [3:0] f_imm_aluop(input logic [5:0] op);
        case (op)
            6'b001000: f_imm_aluop = ALUOP_ADDI;
            6'b001001: f_imm_aluop = ALUOP_ADDIU;
            6'b001010: f_imm_aluop = ALUOP_SLTI;
            6'b001011: f_imm_aluop = ALUOP_SLTIU;
            6'b001100: f_imm_aluop = ALUOP_ANDI;
            6'b001101: f_imm_aluop = ALUOP_ORI;
            6'b001110: f_imm_aluop = ALUOP_XORI;
            6'b001111: f_imm_aluop = ALUOP_LUI;
            default:   f_imm_aluop = 4'hF;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;
    logic             w_is_imm;
    logic             w_legal;

    logic       w_pcwrite, w_irwrite, w_iord, w_memread, w_memwrite, w_regwrite;
    logic [1:0] w_regdst, w_memtoreg, w_alusrcb, w_pcsource;
    logic       w_alusrca, w_illegal;
    logic [3:0] w_aluop;

    assign w_is_imm = (f_imm_aluop(Op) != 4'hF);
    assign w_legal  = (Op == OP_R) ? f_funct_ok(Funct)
                    : (Op == OP_J || Op == OP_JAL || Op == OP_BEQ || Op == OP_BNE ||
                       Op == OP_LW || Op == OP_SW || w_is_imm);

    // Raw control decode and next-state selection
    always_comb begin
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 2'b00;
        w_memtoreg = 2'b00;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluop    = ALUOP_LS;
        w_pcsource = 2'b00;
        w_illegal  = 1'b0;
        w_next     = r_state;
        w_retire   = 1'b0;
        case (r_state)
            S_IF: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                if (MemReady) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_ID;
                end else begin
                    w_next    = S_IF;
                end
            end
            S_ID: begin
                w_alusrcb = 2'b11;
                if (Op == OP_J || Op == OP_JAL) begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'b10;
                    w_next     = S_IF;
                    w_retire   = 1'b1;
                    if (Op == OP_JAL) begin
                        w_regwrite = 1'b1;
                        w_regdst   = 2'b10;
                        w_memtoreg = 2'b10;
                    end else begin
                        w_regwrite = 1'b0;
                    end
                end else if (!w_legal) begin
                    // Dropped without retiring; no writes of any kind
                    w_illegal = 1'b1;
                    w_next    = S_IF;
                end else begin
                    w_next    = S_EX;
                end
            end
            S_EX: begin
                if (Op == OP_R && (Funct == FN_JR || Funct == FN_JALR)) begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'b11;
                    w_next     = S_IF;
                    w_retire   = 1'b1;
                    if (Funct == FN_JALR) begin
                        w_regwrite = 1'b1;
                        w_regdst   = 2'b01;
                        w_memtoreg = 2'b10;
                    end else begin
                        w_regwrite = 1'b0;
                    end
                end else if (Op == OP_R) begin
                    w_alusrca = 1'b1;
                    w_aluop   = ALUOP_RTYPE;
                    w_next    = S_WB;
                end else if (Op == OP_BEQ || Op == OP_BNE) begin
                    w_alusrca  = 1'b1;
                    w_aluop    = (Op == OP_BEQ) ? ALUOP_BEQ : ALUOP_BNE;
                    w_pcsource = 2'b01;
                    w_pcwrite  = (Op == OP_BEQ) ? Zero : ~Zero;
                    w_next     = S_IF;
                    w_retire   = 1'b1;
                end else if (Op == OP_LW || Op == OP_SW) begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                    w_next    = S_MEM;
                end else if (w_is_imm) begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                    w_aluop   = f_imm_aluop(Op);
                    w_next    = S_WB;
                end else begin
                    w_next    = S_IF;
                end
            end
            S_MEM: begin
                w_iord     = 1'b1;
                w_memread  = (Op == OP_LW);
                w_memwrite = (Op == OP_SW);
                if (MemReady) begin
                    if (Op == OP_LW) begin
                        w_next   = S_WB;
                    end else begin
                        w_next   = S_IF;
                        w_retire = 1'b1;
                    end
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_regdst   = (Op == OP_R)  ? 2'b01 : 2'b00;
                w_memtoreg = (Op == OP_LW) ? 2'b01 : 2'b00;
                w_next     = S_IF;
                w_retire   = 1'b1;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // Output stage: reset kills every request immediately, even mid-access
    always_comb begin
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 2'b00;
            MemtoReg = 2'b00;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 4'd0;
            PCSource = 2'b00;
            Illegal  = 1'b0;
        end else begin
            PCWrite  = w_pcwrite;
            IRWrite  = w_irwrite;
            IorD     = w_iord;
            MemRead  = w_memread;
            MemWrite = w_memwrite;
            RegWrite = w_regwrite;
            RegDst   = w_regdst;
            MemtoReg = w_memtoreg;
            ALUSrcA  = w_alusrca;
            ALUSrcB  = w_alusrcb;
            ALUOp    = w_aluop;
            PCSource = w_pcsource;
            Illegal  = w_illegal;
        end
    end

    assign State   = r_state;
    assign InstRet = r_instret;

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IF;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_ONE;
            end else begin
                r_instret <= r_instret;
            end
        end
    end

endmodule
